// File: rtl/code_loader_pkg.sv
// Shared types and helpers for the code_loader block.
// State list includes StChk, reachable only when CODE_LOADER_CHECKSUM_EN is defined.
package code_loader_pkg;

  localparam int unsigned CntW = 9;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StHi,
    StLo,
    StChk,
    StFin
  } state_e;

  // A length byte of zero stands for a full 256-word image.
  function automatic logic [CntW-1:0] len_to_count(input logic [7:0] len);
    return (len == 8'h00) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/code_loader.sv
// Byte-stream loader that writes 16-bit instruction words into code memory.
// Define CODE_LOADER_CHECKSUM_EN to expect a trailing checksum byte per session.
module code_loader
  import code_loader_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        we,
  output logic [7:0]  waddr,
  output logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_e            state_q, state_d;
  logic [7:0]        waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              accept;

`ifdef CODE_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              error_q, error_d;
`endif

  assign in_ready = (state_q == StLen) || (state_q == StHi) ||
                    (state_q == StLo)  || (state_q == StChk);
  assign accept   = in_valid && in_ready;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFin);

`ifdef CODE_LOADER_CHECKSUM_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    error_d = error_q;
`endif

    // Address advances in the cycle after each write strobe.
    if (we_q) begin
      waddr_d = waddr_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLen;
          waddr_d = BASE_ADDR;
`ifdef CODE_LOADER_CHECKSUM_EN
          sum_d   = 8'h00;
          error_d = 1'b0;
`endif
        end
      end
      StLen: begin
        if (accept) begin
          cnt_d   = len_to_count(in_data);
          state_d = StHi;
        end
      end
      StHi: begin
        if (accept) begin
          wdata_d[15:8] = in_data;
`ifdef CODE_LOADER_CHECKSUM_EN
          sum_d         = sum_q + in_data;
`endif
          state_d       = StLo;
        end
      end
      StLo: begin
        if (accept) begin
          wdata_d[7:0] = in_data;
`ifdef CODE_LOADER_CHECKSUM_EN
          sum_d        = sum_q + in_data;
`endif
          we_d         = 1'b1;
          cnt_d        = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
`ifdef CODE_LOADER_CHECKSUM_EN
            state_d = StChk;
`else
            state_d = StFin;
`endif
          end else begin
            state_d = StHi;
          end
        end
      end
      StChk: begin
`ifdef CODE_LOADER_CHECKSUM_EN
        if (accept) begin
          // Flag raised here so it is already visible alongside done.
          error_d = ((sum_q + in_data) != 8'h00);
          state_d = StFin;
        end
`else
        state_d = StIdle;
`endif
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      waddr_q <= BASE_ADDR;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CODE_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q   <= 8'h00;
      error_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      error_q <= error_d;
    end
  end
`endif

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: cycle table plus directed session sequences.
// Two instances share stimulus: BASE_ADDR 8'h00 and 8'hFE.
module tb_code_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        rdy0, we0, busy0, done0, err0;
  logic [7:0]  waddr0;
  logic [15:0] wdata0;
  logic        rdy1, we1, busy1, done1, err1;
  logic [7:0]  waddr1;
  logic [15:0] wdata1;

  code_loader #(.BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .we(we0), .waddr(waddr0), .wdata(wdata0), .busy(busy0),
    .done(done0), .error(err0)
  );

  code_loader #(.BASE_ADDR(8'hFE)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .we(we1), .waddr(waddr1), .wdata(wdata1), .busy(busy1),
    .done(done1), .error(err1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0]  a0_q[$], a1_q[$];
  logic [15:0] d0_q[$], d1_q[$];
  int          t0_q[$];
  int          done0_cnt = 0, done1_cnt = 0;
  logic [15:0] words_q[$];

`ifdef CODE_LOADER_CHECKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we0) begin
      a0_q.push_back(waddr0);
      d0_q.push_back(wdata0);
      t0_q.push_back(cyc);
    end
    if (we1) begin
      a1_q.push_back(waddr1);
      d1_q.push_back(wdata1);
    end
    if (done0) done0_cnt++;
    if (done1) done1_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic        v;
    logic [7:0]  d;
    logic [28:0] exp;
  } vec_t;

  vec_t tbl[12];
  int   ntbl = 0;

  // Expected output bundle {in_ready, we, waddr, wdata, busy, done, error}.
  function automatic logic [28:0] o(input logic r, input logic w, input logic [7:0] a,
                                    input logic [15:0] wd, input logic b, input logic dn);
    return {r, w, a, wd, b, dn, 1'b0};
  endfunction

  function automatic void add(input logic st, input logic v, input logic [7:0] d,
                              input logic [28:0] exp);
    tbl[ntbl].st  = st;
    tbl[ntbl].v   = v;
    tbl[ntbl].d   = d;
    tbl[ntbl].exp = exp;
    ntbl++;
  endfunction

  task automatic clr();
    a0_q.delete(); a1_q.delete(); d0_q.delete(); d1_q.delete(); t0_q.delete();
    done0_cnt = 0;
    done1_cnt = 0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int gap, input logic st);
    int tmo;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    start    = st;
    tmo = 0;
    while (!rdy0 && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 50) check("handshake_timeout", 64'd1, 64'd0);
    @(posedge clk);
  endtask

  task automatic start_session();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams words_q; chk_force < 0 sends the correct checksum byte.
  task automatic feed_session(input int gapmax, input int st_at, input int chk_force);
    int         n, k, gap, tmo;
    logic [7:0] nb, sum, b;
    n   = words_q.size();
    nb  = n[7:0];
    sum = 8'h00;
    k   = 0;
    push_byte(nb, 0, 1'b0);
    foreach (words_q[i]) begin
      for (int h = 0; h < 2; h++) begin
        b   = (h == 0) ? words_q[i][15:8] : words_q[i][7:0];
        sum = sum + b;
        gap = (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax));
        push_byte(b, gap, (k == st_at));
        k++;
      end
    end
    if (ChkEn) begin
      b = (chk_force < 0) ? (8'h00 - sum) : chk_force[7:0];
      push_byte(b, 0, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    tmo = 0;
    while (busy0 && tmo < 10) begin
      @(negedge clk);
      tmo++;
    end
    check("session_end_busy0", busy0, 1'b0);
    check("session_end_busy1", busy1, 1'b0);
  endtask

  task automatic cmp_writes(input string name);
    logic [7:0] ea0, ea1;
    check({name, "_count0"}, a0_q.size(), words_q.size());
    check({name, "_count1"}, a1_q.size(), words_q.size());
    for (int i = 0; i < words_q.size() && i < a0_q.size() && i < a1_q.size(); i++) begin
      ea0 = 8'(i);
      ea1 = 8'(8'hFE + i);
      check($sformatf("%s_addr0_%0d", name, i), a0_q[i], ea0);
      check($sformatf("%s_data0_%0d", name, i), d0_q[i], words_q[i]);
      check($sformatf("%s_addr1_%0d", name, i), a1_q[i], ea1);
      check($sformatf("%s_data1_%0d", name, i), d1_q[i], words_q[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_out0", {rdy0, we0, waddr0, wdata0, busy0, done0, err0}, o(0, 0, 8'h00, 16'h0000, 0, 0));
    check("reset_out1", {rdy1, we1, waddr1, wdata1, busy1, done1, err1}, o(0, 0, 8'hFE, 16'h0000, 0, 0));
    reset_n = 1'b1;

    // Cycle table: N=2 session 70 05 28 01 with idle noise, a wait and a stray start.
    add(0, 1, 8'hAA, o(0, 0, 8'h00, 16'h0000, 0, 0));
    add(1, 0, 8'h00, o(0, 0, 8'h00, 16'h0000, 0, 0));
    add(0, 0, 8'h00, o(1, 0, 8'h00, 16'h0000, 1, 0));
    add(0, 1, 8'h02, o(1, 0, 8'h00, 16'h0000, 1, 0));
    add(1, 1, 8'h70, o(1, 0, 8'h00, 16'h0000, 1, 0));
    add(0, 1, 8'h05, o(1, 0, 8'h00, 16'h7000, 1, 0));
    add(0, 1, 8'h28, o(1, 1, 8'h00, 16'h7005, 1, 0));
    add(0, 0, 8'h00, o(1, 0, 8'h01, 16'h2805, 1, 0));
    add(0, 1, 8'h01, o(1, 0, 8'h01, 16'h2805, 1, 0));
    if (ChkEn) begin
      add(0, 1, 8'h62, o(1, 1, 8'h01, 16'h2801, 1, 0));
      add(0, 0, 8'h00, o(0, 0, 8'h02, 16'h2801, 1, 1));
    end else begin
      add(0, 0, 8'h00, o(0, 1, 8'h01, 16'h2801, 1, 1));
    end
    add(0, 0, 8'h00, o(0, 0, 8'h02, 16'h2801, 0, 0));

    clr();
    for (int i = 0; i < ntbl; i++) begin
      @(negedge clk);
      start    = tbl[i].st;
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      check($sformatf("vec%0d", i), {rdy0, we0, waddr0, wdata0, busy0, done0, err0}, tbl[i].exp);
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    words_q = '{16'h7005, 16'h2801};
    cmp_writes("tbl");

    // BASE_ADDR FE wraps through FF to 00.
    clr();
    words_q = '{16'h1111, 16'h2222, 16'h3333};
    start_session();
    feed_session(0, -1, -1);
    cmp_writes("wrap");
    check("wrap_done1", done1_cnt, 1);
    check("wrap_err0", err0, 1'b0);

    // Full 256-word session, continuous stream.
    clr();
    words_q.delete();
    for (int i = 0; i < 256; i++) words_q.push_back({8'(i), ~8'(i)});
    start_session();
    feed_session(0, -1, -1);
    cmp_writes("full");
    bad = 0;
    for (int i = 1; i < t0_q.size(); i++) if (t0_q[i] - t0_q[i-1] != 2) bad++;
    check("full_spacing", bad, 0);
    check("full_done0", done0_cnt, 1);

    // Checksum byte 00 on N=1 word 1234: error only when checksum is enabled.
    clr();
    words_q = '{16'h1234};
    start_session();
    feed_session(0, -1, 0);
    cmp_writes("chk");
    check("chk_done0", done0_cnt, 1);
    check("chk_err_after", err0, ChkEn);
    repeat (5) @(negedge clk);
    check("chk_err_held", err0, ChkEn);
    clr();
    words_q = '{16'hABCD};
    start_session();
    check("chk_err_cleared", err0, 1'b0);
    feed_session(0, -1, -1);
    cmp_writes("chk2");

    // Reset after the HI byte of word 2.
    clr();
    start_session();
    push_byte(8'h03, 0, 1'b0);
    push_byte(8'hDE, 0, 1'b0);
    push_byte(8'hAD, 0, 1'b0);
    push_byte(8'hBE, 0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_out0", {rdy0, we0, waddr0, wdata0, busy0, done0, err0}, o(0, 0, 8'h00, 16'h0000, 0, 0));
    check("rst_out1", {rdy1, we1, waddr1, wdata1, busy1, done1, err1}, o(0, 0, 8'hFE, 16'h0000, 0, 0));
    check("rst_prior_writes", a0_q.size(), 1);
    repeat (3) @(negedge clk);
    reset_n  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEF;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    check("rst_no_more_we", a0_q.size(), 1);
    check("rst_idle_busy", busy0, 1'b0);
    clr();
    words_q = '{16'h5A5A};
    start_session();
    feed_session(0, -1, -1);
    cmp_writes("rst_reload");

    // Stray start mid-session with random gaps.
    clr();
    words_q = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0789};
    start_session();
    feed_session(3, 3, -1);
    cmp_writes("gaps");
    check("gaps_done0", done0_cnt, 1);
    check("gaps_err0", err0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
